m6502_core: RTL and testbench
=============================

# m6502_core

Instruction-decode front end of the M6502 CPU core. It latches the fetched opcode byte and decodes it combinationally into an operation mnemonic, an addressing mode, a memory access type and an index-register select. The downstream cycle sequencer and ALU use these outputs. It sits between the bus interface (opcode fetch) and the execution state machine.

## Interface
- No parameters.
- `i_clk` in 1: core clock, rising edge.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_data` in 8: data bus byte, the opcode during fetch.
- `i_opcodeLoad` in 1: fetch strobe; latch `i_data` into `r_opcode` at this edge.
- `o_operation` out `Operation`: decoded mnemonic, driven from `r_operation`.
- `o_addressingMode` out `AddressingMode`: driven from `r_addressingMode`.
- `o_accessType` out `AccessType`: driven from `r_operationAccessType`.
- `o_indexY` out 1: 1 means the indexed mode uses Y, 0 means it uses X; 0 for non-indexed modes.
- `o_illegal` out 1: opcode not in the legal 151-opcode set.

Internal signals `r_opcode`, `r_operation`, `r_addressingMode` and `r_operationAccessType` keep exactly these names, because benches probe them hierarchically.

## Operation
The decode of `r_opcode` is pure combinational logic. It uses the 6502 `aaabbbcc` field layout.

**cc=01** (operation by aaa: ORA AND EOR ADC STA LDA CMP SBC)
- bbb to mode: 000 IndexedIndirect; 001 ZeroPage; 010 Immediate; 011 Absolute; 100 IndirectIndexed; 101 ZeroPageIndexed; 110 AbsoluteIndexed with Y; 111 AbsoluteIndexed with X.
- 0x89 is illegal.

**cc=10** (operation by aaa: ASL ROL LSR ROR STX LDX DEC INC)
- bbb to mode: 000 Immediate (LDX only); 001 ZeroPage; 010 Implied (accumulator form, ASL/ROL/LSR/ROR only); 011 Absolute; 101 ZeroPageIndexed; 111 AbsoluteIndexed.
- STX/LDX index with Y; all others with X. 0x9E is illegal.
- Deliberate exception: 0x6E decodes as ROR AbsoluteIndexed, and 0x7E decodes as ROR Absolute.

**cc=00**
- BIT: 24 ZeroPage, 2C Absolute.
- JMP: 4C Absolute, 6C AbsoluteIndirect.
- JSR: 20 Absolute.
- STY: 84 / 94 / 8C.
- LDY: A0 / A4 / B4 / AC / BC.
- CPY: C0 / C4 / CC.
- CPX: E0 / E4 / EC.

**Branches:** Relative mode. 10 BPL, 30 BMI, 50 BVC, 70 BVS, 90 BCC, B0 BCS, D0 BNE, F0 BEQ.

**Implied single-byte opcodes**
- 00 BRK, 08 PHP, 18 CLC, 28 PLP, 38 SEC, 40 RTI, 48 PHA, 58 CLI, 60 RTS, 68 PLA, 78 SEI.
- 88 DEY, 8A TXA, 98 TYA, 9A TXS, A8 TAY, AA TAX, B8 CLV, BA TSX.
- C8 INY, CA DEX, D8 CLD, E8 INX, EA NOP, F8 SED.

**Access type**
- Access_Write: STA, STX, STY, PHA, PHP.
- Access_ReadWrite: ASL, LSR, ROL, ROR, INC, DEC when the mode is not Implied.
- Access_Read: everything else, including the accumulator shifts.

**Illegal opcodes:** decode as NOP / Implied / Access_Read with `o_indexY`=0 and `o_illegal`=1.

## Timing
- Reset value of `r_opcode` is 0xEA. Outputs during reset are therefore NOP, Implied, Access_Read, `o_indexY`=0, `o_illegal`=0.
- `r_opcode` updates on the rising `i_clk` edge when `i_opcodeLoad`=1 and holds otherwise.
- Decoded outputs are valid in the same cycle, after that edge (load-to-output latency is one edge plus combinational delay).
- If reset is asserted in the same cycle as a load, reset wins.

## Configuration
`M6502_TB_HOOKS_EN`:
- Defined: compiles in task `TbSetOpcode(input logic [7:0] opcode)`, which writes `r_opcode` directly with zero delay, bypassing the clock.
- Undefined: the task is absent and `r_opcode` is written only by load or reset.

## Structure
- Package `M6502Defs` holds:
  - enum `Operation`: the 56 legal mnemonics ADC…TYA, with NOP included.
  - enum `AddressingMode`: Implied, Immediate, ZeroPage, ZeroPageIndexed, Absolute, AbsoluteIndexed, IndexedIndirect, IndirectIndexed, Relative, AbsoluteIndirect.
  - enum `AccessType`: Access_Read, Access_Write, Access_ReadWrite.
- The decode lives in one sub-module, `m6502_opcode_decoder`: combinational, 8-bit opcode in, four decoded fields plus the illegal flag out.

## Test plan
- Reset asserted → NOP / Implied / Access_Read, `o_illegal`=0.
- Load 0x79, then 0x7D → both ADC / AbsoluteIndexed / Read; `o_indexY` = 1, then 0.
- Load 0xFE, then 0x0A → INC / AbsoluteIndexed / ReadWrite, then ASL / Implied / Read.
- Load 0x91 and 0x48 → STA / IndirectIndexed / Write, and PHA / Implied / Write.
- Load 0x6E, then 0x7E → ROR / AbsoluteIndexed / ReadWrite, then ROR / Absolute / ReadWrite.
- Load 0x02, 0x89 and 0x9E → each NOP / Implied / Read with `o_illegal`=1.
- Sweep all 151 legal opcodes through `TbSetOpcode` → every opcode matches the Operation table above.

Source files
------------

// File: rtl/m6502_core_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | M6502Defs : shared decode types for the M6502 instruction front  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package M6502Defs;

  typedef enum logic [5:0] {
    ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI, BNE, BPL, BRK, BVC, BVS, CLC,
    CLD, CLI, CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR, INC, INX, INY, JMP,
    JSR, LDA, LDX, LDY, LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL, ROR, RTI,
    RTS, SBC, SEC, SED, SEI, STA, STX, STY, TAX, TAY, TSX, TXA, TXS, TYA
  } Operation;

  typedef enum logic [3:0] {
    Implied, Immediate, ZeroPage, ZeroPageIndexed, Absolute, AbsoluteIndexed,
    IndexedIndirect, IndirectIndexed, Relative, AbsoluteIndirect
  } AddressingMode;

  typedef enum logic [1:0] {
    Access_Read, Access_Write, Access_ReadWrite
  } AccessType;

  localparam logic [7:0] c_RESET_OPCODE = 8'hEA;

  typedef struct packed {
    Operation      op;
    AddressingMode mode;
    logic          index_y;
    logic          legal;
  } decode_t;

  localparam decode_t c_ILLEGAL_DECODE = '{op: NOP, mode: Implied, index_y: 1'b0, legal: 1'b0};

  function automatic decode_t mk_decode(Operation op, AddressingMode mode, logic index_y);
    decode_t d;
    d.op      = op;
    d.mode    = mode;
    d.index_y = index_y;
    d.legal   = 1'b1;
    return d;
  endfunction

  // Accumulator shifts (Implied) touch no memory, so they stay plain reads.
  function automatic AccessType access_of(Operation op, AddressingMode mode);
    AccessType a;
    case (op)
      STA, STX, STY, PHA, PHP:      a = Access_Write;
      ASL, LSR, ROL, ROR, INC, DEC: a = (mode == Implied) ? Access_Read : Access_ReadWrite;
      default:                      a = Access_Read;
    endcase
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/m6502_core_opcode_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | m6502_opcode_decoder : combinational aaabbbcc opcode decode      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module m6502_opcode_decoder
  import M6502Defs::*;
(
  input  logic [7:0]    i_opcode,
  output Operation      o_operation,
  output AddressingMode o_addressingMode,
  output AccessType     o_accessType,
  output logic          o_indexY,
  output logic          o_illegal
);

  logic [2:0] w_aaa;
  logic [2:0] w_bbb;
  logic [1:0] w_cc;
  logic       w_xyReg;
  decode_t    w_dec;

  assign w_aaa   = i_opcode[7:5];
  assign w_bbb   = i_opcode[4:2];
  assign w_cc    = i_opcode[1:0];
  assign w_xyReg = (w_aaa == 3'd4) || (w_aaa == 3'd5);

  always_comb begin
    w_dec = c_ILLEGAL_DECODE;

    case (w_cc)
      2'b01: begin
        w_dec.legal = (i_opcode != 8'h89);
        case (w_aaa)
          3'd0:    w_dec.op = ORA;
          3'd1:    w_dec.op = AND;
          3'd2:    w_dec.op = EOR;
          3'd3:    w_dec.op = ADC;
          3'd4:    w_dec.op = STA;
          3'd5:    w_dec.op = LDA;
          3'd6:    w_dec.op = CMP;
          default: w_dec.op = SBC;
        endcase
        case (w_bbb)
          3'd0: w_dec.mode = IndexedIndirect;
          3'd1: w_dec.mode = ZeroPage;
          3'd2: w_dec.mode = Immediate;
          3'd3: w_dec.mode = Absolute;
          3'd4: begin
            w_dec.mode    = IndirectIndexed;
            w_dec.index_y = 1'b1;
          end
          3'd5: w_dec.mode = ZeroPageIndexed;
          3'd6: begin
            w_dec.mode    = AbsoluteIndexed;
            w_dec.index_y = 1'b1;
          end
          default: w_dec.mode = AbsoluteIndexed;
        endcase
      end

      2'b10: begin
        case (w_aaa)
          3'd0:    w_dec.op = ASL;
          3'd1:    w_dec.op = ROL;
          3'd2:    w_dec.op = LSR;
          3'd3:    w_dec.op = ROR;
          3'd4:    w_dec.op = STX;
          3'd5:    w_dec.op = LDX;
          3'd6:    w_dec.op = DEC;
          default: w_dec.op = INC;
        endcase
        case (w_bbb)
          3'd0: begin
            w_dec.mode  = Immediate;
            w_dec.legal = (w_aaa == 3'd5);
          end
          3'd1: begin
            w_dec.mode  = ZeroPage;
            w_dec.legal = 1'b1;
          end
          3'd2: begin
            w_dec.mode  = Implied;
            w_dec.legal = ~w_aaa[2];
          end
          3'd3: begin
            w_dec.mode  = Absolute;
            w_dec.legal = 1'b1;
          end
          3'd5: begin
            w_dec.mode    = ZeroPageIndexed;
            w_dec.index_y = w_xyReg;
            w_dec.legal   = 1'b1;
          end
          3'd7: begin
            w_dec.mode    = AbsoluteIndexed;
            w_dec.index_y = w_xyReg;
            w_dec.legal   = (i_opcode != 8'h9E);
          end
          default: w_dec.legal = 1'b0;
        endcase
        // ROR keeps the original core's swapped absolute/indexed encodings.
        if (i_opcode == 8'h6E) begin
          w_dec.mode = AbsoluteIndexed;
        end else if (i_opcode == 8'h7E) begin
          w_dec.mode = Absolute;
        end
      end

      default: ;
    endcase

    // Irregular cc=00 opcodes, branches and single-byte implied forms.
    case (i_opcode)
      8'h24: w_dec = mk_decode(BIT, ZeroPage,         1'b0);
      8'h2C: w_dec = mk_decode(BIT, Absolute,         1'b0);
      8'h4C: w_dec = mk_decode(JMP, Absolute,         1'b0);
      8'h6C: w_dec = mk_decode(JMP, AbsoluteIndirect, 1'b0);
      8'h20: w_dec = mk_decode(JSR, Absolute,         1'b0);
      8'h84: w_dec = mk_decode(STY, ZeroPage,         1'b0);
      8'h94: w_dec = mk_decode(STY, ZeroPageIndexed,  1'b0);
      8'h8C: w_dec = mk_decode(STY, Absolute,         1'b0);
      8'hA0: w_dec = mk_decode(LDY, Immediate,        1'b0);
      8'hA4: w_dec = mk_decode(LDY, ZeroPage,         1'b0);
      8'hB4: w_dec = mk_decode(LDY, ZeroPageIndexed,  1'b0);
      8'hAC: w_dec = mk_decode(LDY, Absolute,         1'b0);
      8'hBC: w_dec = mk_decode(LDY, AbsoluteIndexed,  1'b0);
      8'hC0: w_dec = mk_decode(CPY, Immediate,        1'b0);
      8'hC4: w_dec = mk_decode(CPY, ZeroPage,         1'b0);
      8'hCC: w_dec = mk_decode(CPY, Absolute,         1'b0);
      8'hE0: w_dec = mk_decode(CPX, Immediate,        1'b0);
      8'hE4: w_dec = mk_decode(CPX, ZeroPage,         1'b0);
      8'hEC: w_dec = mk_decode(CPX, Absolute,         1'b0);
      8'h10: w_dec = mk_decode(BPL, Relative,         1'b0);
      8'h30: w_dec = mk_decode(BMI, Relative,         1'b0);
      8'h50: w_dec = mk_decode(BVC, Relative,         1'b0);
      8'h70: w_dec = mk_decode(BVS, Relative,         1'b0);
      8'h90: w_dec = mk_decode(BCC, Relative,         1'b0);
      8'hB0: w_dec = mk_decode(BCS, Relative,         1'b0);
      8'hD0: w_dec = mk_decode(BNE, Relative,         1'b0);
      8'hF0: w_dec = mk_decode(BEQ, Relative,         1'b0);
      8'h00: w_dec = mk_decode(BRK, Implied,          1'b0);
      8'h08: w_dec = mk_decode(PHP, Implied,          1'b0);
      8'h18: w_dec = mk_decode(CLC, Implied,          1'b0);
      8'h28: w_dec = mk_decode(PLP, Implied,          1'b0);
      8'h38: w_dec = mk_decode(SEC, Implied,          1'b0);
      8'h40: w_dec = mk_decode(RTI, Implied,          1'b0);
      8'h48: w_dec = mk_decode(PHA, Implied,          1'b0);
      8'h58: w_dec = mk_decode(CLI, Implied,          1'b0);
      8'h60: w_dec = mk_decode(RTS, Implied,          1'b0);
      8'h68: w_dec = mk_decode(PLA, Implied,          1'b0);
      8'h78: w_dec = mk_decode(SEI, Implied,          1'b0);
      8'h88: w_dec = mk_decode(DEY, Implied,          1'b0);
      8'h8A: w_dec = mk_decode(TXA, Implied,          1'b0);
      8'h98: w_dec = mk_decode(TYA, Implied,          1'b0);
      8'h9A: w_dec = mk_decode(TXS, Implied,          1'b0);
      8'hA8: w_dec = mk_decode(TAY, Implied,          1'b0);
      8'hAA: w_dec = mk_decode(TAX, Implied,          1'b0);
      8'hB8: w_dec = mk_decode(CLV, Implied,          1'b0);
      8'hBA: w_dec = mk_decode(TSX, Implied,          1'b0);
      8'hC8: w_dec = mk_decode(INY, Implied,          1'b0);
      8'hCA: w_dec = mk_decode(DEX, Implied,          1'b0);
      8'hD8: w_dec = mk_decode(CLD, Implied,          1'b0);
      8'hE8: w_dec = mk_decode(INX, Implied,          1'b0);
      8'hEA: w_dec = mk_decode(NOP, Implied,          1'b0);
      8'hF8: w_dec = mk_decode(SED, Implied,          1'b0);
      default: ;
    endcase

    if (!w_dec.legal) begin
      w_dec.op      = NOP;
      w_dec.mode    = Implied;
      w_dec.index_y = 1'b0;
    end
  end

  assign o_operation      = w_dec.op;
  assign o_addressingMode = w_dec.mode;
  assign o_accessType     = access_of(w_dec.op, w_dec.mode);
  assign o_indexY         = w_dec.index_y;
  assign o_illegal        = ~w_dec.legal;

endmodule
`default_nettype wire

// File: rtl/m6502_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | m6502_core : opcode latch and decode front end of the M6502 CPU  |
// | Optional macro M6502_TB_HOOKS_EN adds task TbSetOpcode.          |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module m6502_core
  import M6502Defs::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [7:0]    i_data,
  input  logic          i_opcodeLoad,
  output Operation      o_operation,
  output AddressingMode o_addressingMode,
  output AccessType     o_accessType,
  output logic          o_indexY,
  output logic          o_illegal
);

  logic [7:0]    r_opcode;
  Operation      r_operation;
  AddressingMode r_addressingMode;
  AccessType     r_operationAccessType;
  logic          w_indexY;
  logic          w_illegal;

`ifdef M6502_TB_HOOKS_EN
  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_opcode <= c_RESET_OPCODE;
    end else if (i_opcodeLoad) begin
      r_opcode <= i_data;
    end
  end

  // Lets a bench place any opcode in the latch without clocking a fetch.
  task automatic TbSetOpcode(input logic [7:0] opcode);
    r_opcode <= opcode;
  endtask
`else
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_opcode <= c_RESET_OPCODE;
    end else if (i_opcodeLoad) begin
      r_opcode <= i_data;
    end
  end
`endif

  m6502_opcode_decoder u_decoder (
    .i_opcode         (r_opcode),
    .o_operation      (r_operation),
    .o_addressingMode (r_addressingMode),
    .o_accessType     (r_operationAccessType),
    .o_indexY         (w_indexY),
    .o_illegal        (w_illegal)
  );

  assign o_operation      = r_operation;
  assign o_addressingMode = r_addressingMode;
  assign o_accessType     = r_operationAccessType;
  assign o_indexY         = w_indexY;
  assign o_illegal        = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_m6502_core.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_m6502_core : table-model checking bench for m6502_core        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_m6502_core;
  import M6502Defs::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    i_data = 8'h02;
  logic          i_opcodeLoad = 1'b1;
  Operation      o_operation;
  AddressingMode o_addressingMode;
  AccessType     o_accessType;
  logic          o_indexY;
  logic          o_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference decode table, one entry per opcode byte.
  Operation      m_op   [256];
  AddressingMode m_mode [256];
  AccessType     m_acc  [256];
  bit            m_iy   [256];
  bit            m_ill  [256];

  Operation      alu_ops   [8] = '{ORA, AND, EOR, ADC, STA, LDA, CMP, SBC};
  AddressingMode alu_modes [8] = '{IndexedIndirect, ZeroPage, Immediate, Absolute,
                                   IndirectIndexed, ZeroPageIndexed, AbsoluteIndexed, AbsoluteIndexed};
  Operation      rmw_ops   [8] = '{ASL, ROL, LSR, ROR, STX, LDX, DEC, INC};
  int            br_opc    [8] = '{'h10, 'h30, 'h50, 'h70, 'h90, 'hB0, 'hD0, 'hF0};
  Operation      br_ops    [8] = '{BPL, BMI, BVC, BVS, BCC, BCS, BNE, BEQ};
  int            imp_opc  [25] = '{'h00, 'h08, 'h18, 'h28, 'h38, 'h40, 'h48, 'h58, 'h60, 'h68,
                                   'h78, 'h88, 'h8A, 'h98, 'h9A, 'hA8, 'hAA, 'hB8, 'hBA, 'hC8,
                                   'hCA, 'hD8, 'hE8, 'hEA, 'hF8};
  Operation      imp_ops  [25] = '{BRK, PHP, CLC, PLP, SEC, RTI, PHA, CLI, RTS, PLA,
                                   SEI, DEY, TXA, TYA, TXS, TAY, TAX, CLV, TSX, INY,
                                   DEX, CLD, INX, NOP, SED};
  int            directed [11] = '{'h79, 'h7D, 'hFE, 'h0A, 'h91, 'h48, 'h6E, 'h7E, 'h02, 'h89, 'h9E};

  m6502_core dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_data           (i_data),
    .i_opcodeLoad     (i_opcodeLoad),
    .o_operation      (o_operation),
    .o_addressingMode (o_addressingMode),
    .o_accessType     (o_accessType),
    .o_indexY         (o_indexY),
    .o_illegal        (o_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic AccessType exp_access(Operation op, AddressingMode md);
    if (op inside {STA, STX, STY, PHA, PHP}) return Access_Write;
    if ((op inside {ASL, LSR, ROL, ROR, INC, DEC}) && md != Implied) return Access_ReadWrite;
    return Access_Read;
  endfunction

  task automatic legal(input int opc, input Operation op, input AddressingMode md, input bit iy);
    m_op[opc]   = op;
    m_mode[opc] = md;
    m_acc[opc]  = exp_access(op, md);
    m_iy[opc]   = iy;
    m_ill[opc]  = 1'b0;
  endtask

  task automatic build_model();
    int base;
    for (int i = 0; i < 256; i++) begin
      m_op[i] = NOP; m_mode[i] = Implied; m_acc[i] = Access_Read; m_iy[i] = 1'b0; m_ill[i] = 1'b1;
    end
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        if (a * 32 + b * 4 + 1 != 'h89)
          legal(a * 32 + b * 4 + 1, alu_ops[a], alu_modes[b], (b == 4) || (b == 6));
    for (int a = 0; a < 8; a++) begin
      base = a * 32 + 2;
      if (a == 5) legal(base, LDX, Immediate, 1'b0);
      legal(base + 4, rmw_ops[a], ZeroPage, 1'b0);
      if (a < 4) legal(base + 8, rmw_ops[a], Implied, 1'b0);
      legal(base + 12, rmw_ops[a], Absolute, 1'b0);
      legal(base + 20, rmw_ops[a], ZeroPageIndexed, (a == 4) || (a == 5));
      if (base + 28 != 'h9E) legal(base + 28, rmw_ops[a], AbsoluteIndexed, (a == 4) || (a == 5));
    end
    legal('h6E, ROR, AbsoluteIndexed, 1'b0);
    legal('h7E, ROR, Absolute, 1'b0);
    legal('h24, BIT, ZeroPage, 1'b0);  legal('h2C, BIT, Absolute, 1'b0);
    legal('h4C, JMP, Absolute, 1'b0);  legal('h6C, JMP, AbsoluteIndirect, 1'b0);
    legal('h20, JSR, Absolute, 1'b0);
    legal('h84, STY, ZeroPage, 1'b0);  legal('h94, STY, ZeroPageIndexed, 1'b0);
    legal('h8C, STY, Absolute, 1'b0);
    legal('hA0, LDY, Immediate, 1'b0); legal('hA4, LDY, ZeroPage, 1'b0);
    legal('hB4, LDY, ZeroPageIndexed, 1'b0); legal('hAC, LDY, Absolute, 1'b0);
    legal('hBC, LDY, AbsoluteIndexed, 1'b0);
    legal('hC0, CPY, Immediate, 1'b0); legal('hC4, CPY, ZeroPage, 1'b0);
    legal('hCC, CPY, Absolute, 1'b0);
    legal('hE0, CPX, Immediate, 1'b0); legal('hE4, CPX, ZeroPage, 1'b0);
    legal('hEC, CPX, Absolute, 1'b0);
    for (int i = 0; i < 8; i++)  legal(br_opc[i], br_ops[i], Relative, 1'b0);
    for (int i = 0; i < 25; i++) legal(imp_opc[i], imp_ops[i], Implied, 1'b0);
  endtask

  task automatic check_decode(input string ctx, input int opc);
    chk($sformatf("%s[%02h]/op", ctx, opc),   32'(o_operation),      32'(m_op[opc]));
    chk($sformatf("%s[%02h]/mode", ctx, opc), 32'(o_addressingMode), 32'(m_mode[opc]));
    chk($sformatf("%s[%02h]/acc", ctx, opc),  32'(o_accessType),     32'(m_acc[opc]));
    chk($sformatf("%s[%02h]/iy", ctx, opc),   32'(o_indexY),         32'(m_iy[opc]));
    chk($sformatf("%s[%02h]/ill", ctx, opc),  32'(o_illegal),        32'(m_ill[opc]));
  endtask

  task automatic load(input int opc, input string ctx);
    @(negedge clk);
    i_data       = 8'(opc);
    i_opcodeLoad = 1'b1;
    @(posedge clk);
    #1;
    check_decode(ctx, opc);
    chk($sformatf("%s[%02h]/latch", ctx, opc), 32'(dut.r_opcode), 32'(opc));
  endtask

  initial begin
    int exp_opc;
    logic [7:0] d;
    bit ld;

    build_model();

    // Reset held while a load of an illegal opcode is presented: reset wins.
    repeat (2) @(posedge clk);
    #1;
    check_decode("reset", 'hEA);
    chk("reset/latch", 32'(dut.r_opcode), 32'hEA);

    @(negedge clk);
    rst = 1'b0;
    i_opcodeLoad = 1'b0;

    foreach (directed[i]) load(directed[i], "dir");

    load('hA9, "hold0");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_opcodeLoad = 1'b0;
      i_data       = 8'($urandom);
      @(posedge clk);
      #1;
      check_decode("hold", 'hA9);
    end

    for (int i = 0; i < 256; i++) load(i, "sweep");

    exp_opc = 'h00;
    load(exp_opc, "rnd0");
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      d  = 8'($urandom);
      ld = 1'($urandom_range(0, 1));
      i_data       = d;
      i_opcodeLoad = ld;
      @(posedge clk);
      if (ld) exp_opc = int'(d);
      #1;
      check_decode("rnd", exp_opc);
    end

    // Asynchronous reset between edges, then held across a load.
    load('h79, "pre_arst");
    @(negedge clk);
    i_opcodeLoad = 1'b1;
    i_data       = 8'h9E;
    #2;
    rst = 1'b1;
    #1;
    check_decode("arst", 'hEA);
    @(posedge clk);
    #1;
    check_decode("arst_hold", 'hEA);
    @(negedge clk);
    rst = 1'b0;
    i_opcodeLoad = 1'b0;
    load('h7E, "post_arst");

`ifdef M6502_TB_HOOKS_EN
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      if (!m_ill[i]) begin
        dut.TbSetOpcode(8'(i));
        #1;
        check_decode("hook", i);
      end
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
